// File: rtl/keypad_scanner.sv
// keypad_scanner: active-low matrix keypad scanner with debounce, a one-shot
// key event and a held status level. Key identity is reported as a linear code
// row_idx * COLS + col_idx.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row        [ROWS-1:0] row sense lines, 0 = contact closed (pulled up)
//   col        [COLS-1:0] column drive, 0 = column selected
//   key_code   [CODE_W-1:0] last accepted key code (kept after release)
//   key_valid  one-clk pulse per accepted key event
//   key_held   level, accepted key still down
//
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat key_valid
// pulses while a key is held (first after REPEAT_DELAY ticks, then every
// REPEAT_RATE ticks). Without it there is exactly one key_valid per press.
//
// The row inputs are sampled directly on the scan tick; the SCAN_DIV period
// gives the external lines time to settle after a column change.

module keypad_scanner #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8,
  localparam int unsigned CODE_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);

  // Reject configurations the scan/debounce logic cannot honour.
  if (ROWS < 1 || COLS < 1 || SCAN_DIV < 2 || DEBOUNCE < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDebounce, StHeld} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [ROW_W-1:0]  cand_row_q, cand_row_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic              tick;
  logic [ROWS-1:0]   row_low;
  logic              hit_any;
  logic              hit_one;
  logic [ROW_W-1:0]  hit_idx;
  logic              accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  // Set after the first repeat: later intervals use REPEAT_RATE.
  logic             rep_armed_q, rep_armed_d;
`endif

  assign tick = (div_q == DIV_W'(SCAN_DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  // Row pattern decode: any/exactly-one low and the index of the low row.
  always_comb begin
    row_low = ~row;
    hit_any = |row_low;
    hit_one = hit_any && ((row_low & (row_low - ROWS'(1))) == '0);
    hit_idx = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_low[r]) hit_idx = ROW_W'(r);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
`endif

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (hit_any) begin
            state_d   = StScan;
            col_idx_d = '0;
          end
        end
        StScan: begin
          if (hit_one) begin
            cand_row_d = hit_idx;
            if (DEBOUNCE == 1) begin
              accept = 1'b1;
            end else begin
              deb_cnt_d = DEB_W'(1);
              state_d   = StDebounce;
            end
          end else if (hit_any) begin
            // Several rows low on one column: ambiguous (ghosting), drop it.
            state_d = StIdle;
          end else if (col_idx_q == COL_W'(COLS - 1)) begin
            state_d = StIdle;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end
        StDebounce: begin
          if (hit_one && (hit_idx == cand_row_q)) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
              accept = 1'b1;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          // Only the candidate row matters; other keys are ignored here.
          if (row[cand_row_q]) begin
            if (rel_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
              rel_cnt_d  = '0;
              key_held_d = 1'b0;
              state_d    = StIdle;
            end else begin
              rel_cnt_d = rel_cnt_q + DEB_W'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
`endif
          end else begin
            rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if ((!rep_armed_q && rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) ||
                (rep_armed_q && rep_cnt_q == REP_W'(REPEAT_RATE - 1))) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = '0;
              rep_armed_d = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (accept) begin
      // hit_idx equals cand_row_q whenever accept is raised.
      key_code_d  = CODE_W'(int'(hit_idx) * int'(COLS) + int'(col_idx_q));
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      rel_cnt_d   = '0;
      state_d     = StHeld;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      col_idx_q   <= '0;
      cand_row_q  <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      cand_row_q  <= cand_row_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  // Idle drives every column so any key press pulls a row low.
  always_comb begin
    col = '1;
    if (state_q == StIdle) begin
      col = '0;
    end else begin
      col[col_idx_q] = 1'b0;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3,
// REPEAT_DELAY=8, REPEAT_RATE=2). A passive keypad model pulls row r low
// when key r*4+c is pressed and column c is driven low.

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulse_q[$];

  keypad_scanner #(
    .ROWS         (4),
    .COLS         (4),
    .SCAN_DIV     (4),
    .DEBOUNCE     (3),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Record the cycle number of every key_valid pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (key_valid === 1'b1) pulse_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int n0, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      step(1);
      if (pulse_q.size() > n0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pressed = '0;
    step(2);
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL reset_col got %b want 0000", col); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_basic_press();
    int n0;
    bit ok;
    n0 = pulse_q.size();
    pressed = 16'h1 << 9;
    wait_pulse(n0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no pulse want pulse"); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL basic_code got %0d want 9", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL basic_held got %b want 1", key_held); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", key_valid); end
    step(20);
    checks++; if (pulse_q.size() !== n0 + 1) begin
      errors++; $display("FAIL basic_single got %0d pulses want 1", pulse_q.size() - n0);
    end
    pressed = '0;
    step(8);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL basic_early_release got %b want 1", key_held); end
    step(4);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL basic_release got %b want 0", key_held); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL basic_code_kept got %0d want 9", key_code); end
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL basic_idle_col got %b want 0000", col); end
    step(4);
  endtask

  task automatic test_col_walk();
    logic [3:0] seen[$];
    logic [3:0] want[4];
    logic [3:0] prev;
    int n0;
    bit ok;
    want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b1011; want[3] = 4'b0111;
    n0   = pulse_q.size();
    prev = col;
    pressed = 16'h1 << 15;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step(1);
      if (col !== prev) begin
        seen.push_back(col);
        prev = col;
      end
      if (pulse_q.size() > n0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL walk_timeout got no pulse want pulse"); end
    checks++; if (seen.size() !== 4) begin errors++; $display("FAIL walk_len got %0d want 4", seen.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= seen.size()) begin
        errors++; $display("FAIL walk_step%0d got none want %b", k, want[k]);
      end else if (seen[k] !== want[k]) begin
        errors++; $display("FAIL walk_step%0d got %b want %b", k, seen[k], want[k]);
      end
    end
    checks++; if (key_code !== 4'd15) begin errors++; $display("FAIL walk_code got %0d want 15", key_code); end
    pressed = '0;
    step(16);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL walk_release got %b want 0", key_held); end
  endtask

  task automatic test_bounce();
    int n0;
    bit ok;
    n0 = pulse_q.size();
    pressed = 16'h1 << 5;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step(1);
      if (col === 4'b1101) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bounce_col1 got %b want 1101", col); end
    // Two hit ticks follow (count reaches 2 of 3), then the contact opens.
    step(8);
    pressed = '0;
    step(30);
    checks++; if (pulse_q.size() !== n0) begin
      errors++; $display("FAIL bounce_event got %0d pulses want 0", pulse_q.size() - n0);
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held got %b want 0", key_held); end
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL bounce_idle_col got %b want 0000", col); end
  endtask

  task automatic test_ghost();
    int n0;
    n0 = pulse_q.size();
    pressed = (16'h1 << 0) | (16'h1 << 4);
    step(100);
    checks++; if (pulse_q.size() !== n0) begin
      errors++; $display("FAIL ghost_event got %0d pulses want 0", pulse_q.size() - n0);
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held got %b want 0", key_held); end
    pressed = '0;
    step(8);
  endtask

  task automatic test_async_reset();
    int n0;
    bit ok;
    n0 = pulse_q.size();
    pressed = 16'h1 << 6;
    wait_pulse(n0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL areset_press got no pulse want pulse"); end
    step(3);
    checks++; if (col !== 4'b1011) begin errors++; $display("FAIL areset_held_col got %b want 1011", col); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (col !== 4'b0000) begin errors++; $display("FAIL areset_col got %b want 0000", col); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL areset_code got %0d want 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL areset_held got %b want 0", key_held); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", key_valid); end
    step(3);
    pressed = '0;
    rst_n   = 1'b1;
    step(20);
    checks++; if (pulse_q.size() !== n0 + 1) begin
      errors++; $display("FAIL areset_no_pulse got %0d pulses want 1", pulse_q.size() - n0);
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int n0;
    int first;
    int want_off[4];
    bit ok;
    want_off[0] = 32; want_off[1] = 40; want_off[2] = 48; want_off[3] = 56;
    n0 = pulse_q.size();
    pressed = 16'h1 << 3;
    wait_pulse(n0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL repeat_press got no pulse want pulse"); end
    first = ok ? pulse_q[n0] : 0;
    step(60);
    pressed = '0;
    step(20);
    checks++; if (pulse_q.size() !== n0 + 5) begin
      errors++; $display("FAIL repeat_count got %0d pulses want 5", pulse_q.size() - n0);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (pulse_q.size() <= n0 + k) begin
        errors++; $display("FAIL repeat_pulse%0d got none want +%0d cycles", k, want_off[k-1]);
      end else if (pulse_q[n0+k] - first !== want_off[k-1]) begin
        errors++;
        $display("FAIL repeat_pulse%0d got +%0d want +%0d cycles", k, pulse_q[n0+k] - first,
                 want_off[k-1]);
      end
    end
  endtask
`else
  task automatic test_no_repeat();
    int n0;
    bit ok;
    n0 = pulse_q.size();
    pressed = 16'h1 << 3;
    wait_pulse(n0, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL norep_press got no pulse want pulse"); end
    step(200);
    checks++; if (pulse_q.size() !== n0 + 1) begin
      errors++; $display("FAIL norep_count got %0d pulses want 1", pulse_q.size() - n0);
    end
    checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL norep_code got %0d want 3", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL norep_held got %b want 1", key_held); end
    pressed = '0;
    step(20);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL norep_release got %b want 0", key_held); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_press();
    test_col_walk();
    test_bounce();
    test_ghost();
    test_async_reset();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
